// File: rtl/regfile_wb_arb.sv
// Write-port arbiter for the 32x32 regfile: merges pipeline writeback and buffered long results,
// and tracks registers awaiting long results. Optional macro WB_CONFLICT_CHK_EN adds errFlag.
module regfile_wb_arb #(
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        pipeWen,
   input  logic [4:0]  pipeWAddr,
   input  logic [31:0] pipeWData,
   input  logic        longValid,
   output logic        longReady,
   input  logic [4:0]  longWAddr,
   input  logic [31:0] longWData,
   input  logic        issueLong,
   input  logic [4:0]  issueRd,
   input  logic [4:0]  chkRAddr1,
   input  logic [4:0]  chkRAddr2,
   output logic        hazStall,
   output logic [31:0] busyVec,
   output logic        regWen,
   output logic [4:0]  regWAddr,
   output logic [31:0] regWData
`ifdef WB_CONFLICT_CHK_EN
   ,
   output logic        errFlag
`endif
);

   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

   logic [4:0]    fifo_addr [FIFO_DEPTH];
   logic [31:0]   fifo_data [FIFO_DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [CW-1:0] count;

   logic          fifo_empty;
   logic          long_fire;
   logic          enq;
   logic          deq;
   logic          sel_valid;
   logic          sel_long;
   logic [4:0]    sel_addr;
   logic [31:0]   sel_data;
   logic [CW-1:0] count_nxt;
   logic [31:0]   busy_nxt;

   assign fifo_empty = (count == '0);
   assign longReady  = (count != CW'(FIFO_DEPTH));
   assign long_fire  = longValid & longReady;

   assign hazStall = ((chkRAddr1 != 5'd0) & busyVec[chkRAddr1])
                   | ((chkRAddr2 != 5'd0) & busyVec[chkRAddr2])
                   | (issueLong & (issueRd != 5'd0) & busyVec[issueRd]);

   // Source select: pipeline first, then FIFO head, then long pass-through when FIFO is empty.
   always_comb begin
      sel_valid = 1'b0;
      sel_long  = 1'b0;
      sel_addr  = 5'd0;
      sel_data  = 32'd0;
      deq       = 1'b0;
      enq       = long_fire & (pipeWen | ~fifo_empty);
      if (pipeWen) begin
         sel_valid = 1'b1;
         sel_addr  = pipeWAddr;
         sel_data  = pipeWData;
      end else if (!fifo_empty) begin
         sel_valid = 1'b1;
         sel_long  = 1'b1;
         sel_addr  = fifo_addr[rd_ptr];
         sel_data  = fifo_data[rd_ptr];
         deq       = 1'b1;
      end else if (long_fire) begin
         sel_valid = 1'b1;
         sel_long  = 1'b1;
         sel_addr  = longWAddr;
         sel_data  = longWData;
      end
   end

   // Scoreboard next state: clear on long write, then set on issue so set wins.
   always_comb begin
      busy_nxt  = busyVec;
      count_nxt = count + CW'(enq) - CW'(deq);
      if (sel_long)
         busy_nxt[sel_addr] = 1'b0;
      if (issueLong && (issueRd != 5'd0))
         busy_nxt[issueRd] = 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         regWen   <= 1'b0;
         regWAddr <= 5'd0;
         regWData <= 32'd0;
         busyVec  <= 32'd0;
         count    <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
      end else begin
         regWen   <= sel_valid & (sel_addr != 5'd0);
         regWAddr <= sel_addr;
         regWData <= sel_data;
         busyVec  <= busy_nxt;
         count    <= count_nxt;
         if (deq)
            rd_ptr <= rd_ptr + PW'(1);
         if (enq)
            wr_ptr <= wr_ptr + PW'(1);
      end
   end

   // Buffer storage needs no reset; validity is carried by count.
   always_ff @(posedge clk) begin
      if (enq) begin
         fifo_addr[wr_ptr] <= longWAddr;
         fifo_data[wr_ptr] <= longWData;
      end
   end

`ifdef WB_CONFLICT_CHK_EN
   logic       err_set;
   logic [4:0] err_addr;

   always_comb begin
      err_set  = 1'b0;
      err_addr = 5'd0;
      if (pipeWen && (pipeWAddr != 5'd0) && busyVec[pipeWAddr]) begin
         err_set  = 1'b1;
         err_addr = pipeWAddr;
      end else if (long_fire && (longWAddr != 5'd0) && !busyVec[longWAddr]) begin
         err_set  = 1'b1;
         err_addr = longWAddr;
      end else if (issueLong && (issueRd != 5'd0) && busyVec[issueRd]) begin
         err_set  = 1'b1;
         err_addr = issueRd;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         errFlag <= 1'b0;
      else if (err_set)
         errFlag <= 1'b1;
   end

`ifndef SYNTHESIS
   always_ff @(posedge clk) begin
      if (reset && err_set)
         $display("regfile_wb_arb: writeback conflict on x%0d", err_addr);
   end
`endif
`endif

endmodule

// File: tb/tb_regfile_wb_arb.sv
// Scoreboard bench for regfile_wb_arb: expected regfile writes are queued at stimulus time
// and popped by a negedge monitor; scenario tasks check scoreboard, stall and reset state inline.
module tb_regfile_wb_arb;

   logic        clk = 1'b0;
   logic        reset;
   logic        pipeWen;
   logic [4:0]  pipeWAddr;
   logic [31:0] pipeWData;
   logic        longValid;
   logic        longReady;
   logic [4:0]  longWAddr;
   logic [31:0] longWData;
   logic        issueLong;
   logic [4:0]  issueRd;
   logic [4:0]  chkRAddr1;
   logic [4:0]  chkRAddr2;
   logic        hazStall;
   logic [31:0] busyVec;
   logic        regWen;
   logic [4:0]  regWAddr;
   logic [31:0] regWData;
`ifdef WB_CONFLICT_CHK_EN
   logic        errFlag;
`endif

   int compared   = 0;
   int mismatched = 0;
   logic [36:0] exp_q [$];

   regfile_wb_arb #(.FIFO_DEPTH(2)) dut (
      .clk(clk), .reset(reset),
      .pipeWen(pipeWen), .pipeWAddr(pipeWAddr), .pipeWData(pipeWData),
      .longValid(longValid), .longReady(longReady),
      .longWAddr(longWAddr), .longWData(longWData),
      .issueLong(issueLong), .issueRd(issueRd),
      .chkRAddr1(chkRAddr1), .chkRAddr2(chkRAddr2),
      .hazStall(hazStall), .busyVec(busyVec),
      .regWen(regWen), .regWAddr(regWAddr), .regWData(regWData)
`ifdef WB_CONFLICT_CHK_EN
      , .errFlag(errFlag)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation ran past its time limit");
      $fatal(1, "timeout");
   end

   // Every regfile write must match the head of the expected queue.
   always @(negedge clk) begin
      if (reset === 1'b1 && regWen === 1'b1) begin
         compared++;
         if (exp_q.size() == 0) begin
            mismatched++;
            $display("FAIL wr_unexpected: got x%0d=%h, expected no write", regWAddr, regWData);
         end else begin
            logic [36:0] e;
            e = exp_q.pop_front();
            if ({regWAddr, regWData} !== e) begin
               mismatched++;
               $display("FAIL wr_order: got x%0d=%h, expected x%0d=%h",
                        regWAddr, regWData, e[36:32], e[31:0]);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      pipeWen = 1'b0; pipeWAddr = 5'd0; pipeWData = 32'd0;
      longValid = 1'b0; longWAddr = 5'd0; longWData = 32'd0;
      issueLong = 1'b0; issueRd = 5'd0;
      chkRAddr1 = 5'd0; chkRAddr2 = 5'd0;
   endtask

   task automatic issue(input logic [4:0] rd);
      issueLong = 1'b1; issueRd = rd;
      step();
      issueLong = 1'b0; issueRd = 5'd0;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1'b0;
      #3;
      compared++;
      if ({regWen, regWAddr, regWData} !== 38'd0) begin
         mismatched++;
         $display("FAIL reset_out: got wen=%b a=%0d d=%h, expected 0", regWen, regWAddr, regWData);
      end
      compared++;
      if (busyVec !== 32'd0 || longReady !== 1'b1 || hazStall !== 1'b0) begin
         mismatched++;
         $display("FAIL reset_state: got busy=%h rdy=%b haz=%b, expected 0/1/0", busyVec, longReady, hazStall);
      end
`ifdef WB_CONFLICT_CHK_EN
      compared++;
      if (errFlag !== 1'b0) begin
         mismatched++;
         $display("FAIL reset_err: got %b, expected 0", errFlag);
      end
`endif
      @(negedge clk);
      reset = 1'b1;
      step();
   endtask

   task automatic test_pipe();
      pipeWen = 1'b1; pipeWAddr = 5'd5; pipeWData = 32'hDEAD_BEEF;
      exp_q.push_back({5'd5, 32'hDEAD_BEEF});
      step();
      pipeWAddr = 5'd0; pipeWData = 32'h0BAD_0000;
      step();
      pipeWen = 1'b0;
      compared++;
      if (regWen !== 1'b0) begin
         mismatched++;
         $display("FAIL pipe_x0: got regWen=%b, expected 0", regWen);
      end
      step();
      compared++;
      if (exp_q.size() != 0) begin
         mismatched++;
         $display("FAIL pipe_drain: got %0d pending, expected 0", exp_q.size());
      end
   endtask

   task automatic test_scoreboard();
      issue(5'd7);
      compared++;
      if (busyVec !== 32'h0000_0080) begin
         mismatched++;
         $display("FAIL sb_set: got %h, expected 00000080", busyVec);
      end
      chkRAddr1 = 5'd7;
      #1;
      compared++;
      if (hazStall !== 1'b1) begin
         mismatched++;
         $display("FAIL sb_haz: got %b, expected 1", hazStall);
      end
      chkRAddr1 = 5'd0; chkRAddr2 = 5'd6;
      #1;
      compared++;
      if (hazStall !== 1'b0) begin
         mismatched++;
         $display("FAIL sb_nohaz: got %b, expected 0", hazStall);
      end
      chkRAddr2 = 5'd0;
      longValid = 1'b1; longWAddr = 5'd7; longWData = 32'h0000_1234;
      exp_q.push_back({5'd7, 32'h0000_1234});
      compared++;
      if (longReady !== 1'b1) begin
         mismatched++;
         $display("FAIL sb_ready: got %b, expected 1", longReady);
      end
      step();
      longValid = 1'b0;
      compared++;
      if (busyVec !== 32'd0) begin
         mismatched++;
         $display("FAIL sb_clear: got %h, expected 00000000", busyVec);
      end
      step();
      compared++;
      if (exp_q.size() != 0) begin
         mismatched++;
         $display("FAIL sb_drain: got %0d pending, expected 0", exp_q.size());
      end
   endtask

   task automatic test_contention();
      issue(5'd3); issue(5'd4); issue(5'd9);
      for (int i = 0; i < 4; i++)
         exp_q.push_back({5'(11 + i), 32'hA000_0000 + 32'(i)});
      exp_q.push_back({5'd3, 32'h0000_0033});
      exp_q.push_back({5'd4, 32'h0000_0044});
      exp_q.push_back({5'd9, 32'h0000_0099});
      pipeWen = 1'b1;
      longValid = 1'b1; longWAddr = 5'd3; longWData = 32'h0000_0033;
      for (int i = 0; i < 4; i++) begin
         pipeWAddr = 5'(11 + i); pipeWData = 32'hA000_0000 + 32'(i);
         if (i >= 2) begin
            compared++;
            if (longReady !== 1'b0) begin
               mismatched++;
               $display("FAIL cont_full%0d: got longReady=%b, expected 0", i, longReady);
            end
         end
         step();
         if (i == 0) begin longWAddr = 5'd4; longWData = 32'h0000_0044; end
         if (i == 1) begin longWAddr = 5'd9; longWData = 32'h0000_0099; end
      end
      pipeWen = 1'b0; pipeWAddr = 5'd0; pipeWData = 32'd0;
      compared++;
      if (longReady !== 1'b0) begin
         mismatched++;
         $display("FAIL cont_full_idle: got longReady=%b, expected 0", longReady);
      end
      step();
      compared++;
      if (longReady !== 1'b1) begin
         mismatched++;
         $display("FAIL cont_space: got longReady=%b, expected 1", longReady);
      end
      step();
      longValid = 1'b0;
      for (int i = 0; i < 3; i++) step();
      compared++;
      if (exp_q.size() != 0 || busyVec !== 32'd0) begin
         mismatched++;
         $display("FAIL cont_drain: got %0d pending busy=%h, expected 0/0", exp_q.size(), busyVec);
      end
   endtask

   task automatic test_same_edge();
      issue(5'd10);
      pipeWen = 1'b1; pipeWAddr = 5'd20; pipeWData = 32'h2020_2020;
      longValid = 1'b1; longWAddr = 5'd10; longWData = 32'h0000_00AA;
      exp_q.push_back({5'd20, 32'h2020_2020});
      exp_q.push_back({5'd10, 32'h0000_00AA});
      step();
      pipeWen = 1'b0; longValid = 1'b0;
      issueLong = 1'b1; issueRd = 5'd10;
      step();
      issueLong = 1'b0;
      compared++;
      if (busyVec !== 32'h0000_0400) begin
         mismatched++;
         $display("FAIL same_edge: got busy=%h, expected 00000400", busyVec);
      end
      longValid = 1'b1; longWAddr = 5'd10; longWData = 32'h0000_00BB;
      exp_q.push_back({5'd10, 32'h0000_00BB});
      step();
      longValid = 1'b0;
      step();
      compared++;
      if (exp_q.size() != 0 || busyVec !== 32'd0) begin
         mismatched++;
         $display("FAIL same_drain: got %0d pending busy=%h, expected 0/0", exp_q.size(), busyVec);
      end
   endtask

   task automatic test_reset_mid();
      issue(5'd8);
      pipeWen = 1'b1; pipeWAddr = 5'd0; pipeWData = 32'hFFFF_0000;
      longValid = 1'b1; longWAddr = 5'd8; longWData = 32'h0000_0088;
      step();
      longWAddr = 5'd5; longWData = 32'h0000_0055;
      step();
      pipeWen = 1'b0; longValid = 1'b0;
      compared++;
      if (longReady !== 1'b0 || busyVec !== 32'h0000_0100 || regWData !== 32'hFFFF_0000) begin
         mismatched++;
         $display("FAIL mid_pre: got rdy=%b busy=%h d=%h, expected 0/00000100/ffff0000",
                  longReady, busyVec, regWData);
      end
      #2;
      reset = 1'b0;
      #1;
      compared++;
      if ({regWen, regWAddr, regWData} !== 38'd0 || busyVec !== 32'd0 || longReady !== 1'b1) begin
         mismatched++;
         $display("FAIL mid_reset: got wen=%b a=%0d d=%h busy=%h rdy=%b, expected all 0, rdy 1",
                  regWen, regWAddr, regWData, busyVec, longReady);
      end
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 4; i++) step();
      compared++;
      if (exp_q.size() != 0 || busyVec !== 32'd0) begin
         mismatched++;
         $display("FAIL mid_after: got %0d pending busy=%h, expected 0/0", exp_q.size(), busyVec);
      end
   endtask

`ifdef WB_CONFLICT_CHK_EN
   task automatic test_conflict();
      test_reset();
      issue(5'd7);
      pipeWen = 1'b1; pipeWAddr = 5'd7; pipeWData = 32'h7777_7777;
      exp_q.push_back({5'd7, 32'h7777_7777});
      step();
      pipeWen = 1'b0;
      compared++;
      if (errFlag !== 1'b1) begin
         mismatched++;
         $display("FAIL err_set: got %b, expected 1", errFlag);
      end
      for (int i = 0; i < 3; i++) step();
      compared++;
      if (errFlag !== 1'b1) begin
         mismatched++;
         $display("FAIL err_sticky: got %b, expected 1", errFlag);
      end
      test_reset();
   endtask
`endif

   initial begin
      test_reset();
      test_pipe();
      test_scoreboard();
      test_contention();
      test_same_edge();
      test_reset_mid();
`ifdef WB_CONFLICT_CHK_EN
      test_conflict();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
